// File: rtl/aes_block_stream_if.sv
// 32-bit valid/ready stream pair around the AES block adapter.
// slave: the adapter's view; master: the producer/consumer view.
interface aes_block_stream_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_fault;

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output m_data,
        output m_valid,
        input  m_ready,
        output m_fault
    );

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  m_fault
    );
endinterface

// File: rtl/aes_block_stream.sv
// Packs 32-bit words into 128-bit blocks for aes_top, retries faulted runs,
// and serialises the ciphertext back out as 32-bit words.
module aes_block_stream #(
    parameter int MAX_RETRY = 1,
    parameter int TIMEOUT   = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    aes_block_stream_if.slave bus,
    output logic         aes_start,
    output logic [127:0] aes_key,
    output logic [127:0] aes_plaintext,
    input  logic         aes_busy,
    input  logic         aes_done,
    input  logic [127:0] aes_ciphertext,
    input  logic         aes_fault,
    output logic [15:0]  blk_count,
    output logic         timeout_err
);

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        WAIT,
        DRAIN
    } state_t;

    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);
    // Compared against the pre-increment count: fires as it steps to TIMEOUT-1.
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 2);

    state_t       state;
    state_t       state_n;
    logic [1:0]   wcnt;
    logic [1:0]   dcnt;
    logic [2:0]   retry;
    logic [15:0]  wdog;
    logic [127:0] obuf;
    logic         fault_q;
    logic         rdy_q;

    logic s_acc;
    logic m_hs;
    logic done_ok;
    logic done_retry;
    logic done_fail;
    logic wd_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        aes_start  = 1'b0;
        s_acc      = 1'b0;
        m_hs       = 1'b0;
        done_ok    = 1'b0;
        done_retry = 1'b0;
        done_fail  = 1'b0;
        wd_fire    = 1'b0;
        unique case (state)
            FILL: begin
                s_acc = bus.s_valid & rdy_q;
                if (s_acc && wcnt == 2'd3) begin
                    state_n = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!aes_busy) begin
                    aes_start = 1'b1;
                    state_n   = WAIT;
                end
            end
            WAIT: begin
                if (aes_done) begin
                    if (!aes_fault) begin
                        done_ok = 1'b1;
                        state_n = DRAIN;
                    end else if (retry < RETRY_MAX) begin
                        done_retry = 1'b1;
                        state_n    = LAUNCH;
                    end else begin
                        done_fail = 1'b1;
                        state_n   = DRAIN;
                    end
                end else if (wdog == WDOG_LAST) begin
                    wd_fire = 1'b1;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                m_hs = bus.m_ready;
                if (m_hs && dcnt == 2'd3) begin
                    state_n = FILL;
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

    assign bus.s_ready = rdy_q;
    assign bus.m_valid = (state == DRAIN);
    assign bus.m_data  = bus.m_valid ? obuf[127:96] : 32'h0;
    assign bus.m_fault = bus.m_valid & fault_q;

    // Input side: key register, block assembly, ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q         <= 1'b0;
            wcnt          <= 2'd0;
            aes_key       <= 128'h0;
            aes_plaintext <= 128'h0;
        end else begin
            rdy_q <= (state_n == FILL);
            if (state == FILL && key_load && wcnt == 2'd0) begin
                aes_key <= key_in;
            end
            if (s_acc) begin
                aes_plaintext <= {aes_plaintext[95:0], bus.s_data};
                wcnt          <= wcnt + 2'd1;
            end
        end
    end

    // Run control: watchdog, retries, sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog        <= 16'h0;
            retry       <= 3'd0;
            timeout_err <= 1'b0;
        end else begin
            if (aes_start) begin
                wdog <= 16'h0;
            end else if (state == WAIT) begin
                wdog <= wdog + 16'd1;
            end
            if (done_retry) begin
                retry <= retry + 3'd1;
            end else if (m_hs && dcnt == 2'd3) begin
                retry <= 3'd0;
            end
            if (wd_fire) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Output side: result buffer shifts out MSW first.
    always_ff @(posedge clk) begin
        if (rst) begin
            obuf      <= 128'h0;
            fault_q   <= 1'b0;
            dcnt      <= 2'd0;
            blk_count <= 16'h0;
        end else begin
            if (done_ok) begin
                obuf    <= aes_ciphertext;
                fault_q <= 1'b0;
            end else if (done_fail || wd_fire) begin
                obuf    <= 128'h0;
                fault_q <= 1'b1;
            end else if (m_hs) begin
                obuf <= {obuf[95:0], 32'h0};
            end
            if (m_hs) begin
                dcnt <= dcnt + 2'd1;
                if (dcnt == 2'd3) begin
                    blk_count <= blk_count + 16'd1;
                end
            end
        end
    end

endmodule
